// File: rtl/axi_master_slave.sv
// AXI4 loopback self-test: an internal master writes INCR bursts to a memory-backed slave,
// reads them back and compares. Optional slave backpressure: AXI_MS_BACKPRESSURE_EN.
module axi_master_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 256,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        done,
    output logic        error,
    output logic [15:0] beats_ok
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {M_IDLE, M_WR_ADDR, M_WR_DATA, M_WR_RESP,
                              M_RD_ADDR, M_RD_DATA, M_DONE} m_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} sw_state_t;
    typedef enum logic {R_IDLE, R_DATA} sr_state_t;

    logic                  w_awvalid, w_awready, w_wvalid, w_wready, w_wlast;
    logic                  w_bvalid, w_bready, w_arvalid, w_arready;
    logic                  w_rvalid, w_rready, w_rlast;
    logic [ADDR_WIDTH-1:0] w_awaddr, w_araddr;
    logic [ID_WIDTH-1:0]   w_awid, w_arid, w_bid, w_rid;
    logic [7:0]            w_awlen, w_arlen;
    logic [2:0]            w_awsize, w_arsize;
    logic [1:0]            w_awburst, w_arburst, w_bresp, w_rresp;
    logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
    logic [BYTES-1:0]      w_wstrb;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // ---------------- master ----------------
    m_state_t    r_m_state, w_m_next;
    logic [7:0]  r_burst, r_beat;
    logic        r_done, r_error;
    logic [15:0] r_beats_ok;
    logic        w_last_burst, w_last_beat;
    logic [31:0] w_word_idx;
    logic [DATA_WIDTH-1:0] w_pattern;

    assign w_last_burst = (r_burst == 8'(NUM_BURSTS - 1));
    assign w_last_beat  = (r_beat == 8'(BURST_LEN - 1));
    assign w_word_idx   = 32'(r_burst) * 32'(BURST_LEN) + 32'(r_beat);
    assign w_pattern    = DATA_WIDTH'(32'hC0DE_0000 + w_word_idx);

    assign w_awaddr  = ADDR_WIDTH'(r_burst) * ADDR_WIDTH'(BURST_LEN * BYTES);
    assign w_araddr  = w_awaddr;
    assign w_awid    = '0;
    assign w_arid    = '0;
    assign w_awlen   = 8'(BURST_LEN - 1);
    assign w_arlen   = 8'(BURST_LEN - 1);
    assign w_awsize  = 3'(ADDR_LSB);
    assign w_arsize  = 3'(ADDR_LSB);
    assign w_awburst = BURST_INCR;
    assign w_arburst = BURST_INCR;
    assign w_wdata   = w_pattern;
    assign w_wstrb   = '1;
    assign w_wlast   = w_wvalid && w_last_beat;
    assign w_bready  = (r_m_state != M_IDLE);
    assign w_rready  = (r_m_state != M_IDLE);

    // Master state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_m_state <= M_IDLE;
        else        r_m_state <= w_m_next;
    end

    // Master next-state and channel VALIDs
    always_comb begin
        w_m_next  = r_m_state;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_arvalid = 1'b0;
        case (r_m_state)
            M_IDLE:    w_m_next = M_WR_ADDR;
            M_WR_ADDR: begin
                w_awvalid = 1'b1;
                if (w_awready) w_m_next = M_WR_DATA;
                else           w_m_next = M_WR_ADDR;
            end
            M_WR_DATA: begin
                w_wvalid = 1'b1;
                if (w_wready && w_last_beat) w_m_next = M_WR_RESP;
                else                         w_m_next = M_WR_DATA;
            end
            M_WR_RESP: begin
                if (w_bvalid) w_m_next = w_last_burst ? M_RD_ADDR : M_WR_ADDR;
                else          w_m_next = M_WR_RESP;
            end
            M_RD_ADDR: begin
                w_arvalid = 1'b1;
                if (w_arready) w_m_next = M_RD_DATA;
                else           w_m_next = M_RD_ADDR;
            end
            M_RD_DATA: begin
                if (w_rvalid && w_rlast) w_m_next = w_last_burst ? M_DONE : M_RD_ADDR;
                else                     w_m_next = M_RD_DATA;
            end
            M_DONE:    w_m_next = M_DONE;
            default:   w_m_next = M_IDLE;
        endcase
    end

    // Master counters, read-back compare and status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_burst    <= 8'd0;
            r_beat     <= 8'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_beats_ok <= 16'd0;
        end else begin
            if (w_wvalid && w_wready)      r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
            else if (w_rvalid && w_rready) r_beat <= w_rlast ? 8'd0 : r_beat + 8'd1;
            if (w_bvalid && w_bready) begin
                if (w_bresp != RESP_OKAY || w_bid != '0) r_error <= 1'b1;
                r_burst <= w_last_burst ? 8'd0 : r_burst + 8'd1;
            end else if (w_rvalid && w_rready) begin
                if (w_rdata == w_pattern) r_beats_ok <= r_beats_ok + 16'd1;
                if (w_rdata != w_pattern || w_rresp != RESP_OKAY || w_rid != '0) r_error <= 1'b1;
                if (w_rlast) begin
                    r_burst <= w_last_burst ? 8'd0 : r_burst + 8'd1;
                    r_done  <= r_done | w_last_burst;
                end
            end
        end
    end

    assign done     = r_done;
    assign error    = r_error;
    assign beats_ok = r_beats_ok;

    // ---------------- slave ----------------
    sw_state_t             r_sw_state, w_sw_next;
    sr_state_t             r_sr_state, w_sr_next;
    logic                  r_s_live;
    logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [2:0]            r_wsize, r_rsize;
    logic [1:0]            r_wburst, r_rburst, r_rresp;
    logic [ID_WIDTH-1:0]   r_wid, r_rid;
    logic [7:0]            r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic                  r_werr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_wgap, w_rgap, w_bwait, w_w_end, w_wok;
    logic                  w_ar_hs, w_r_hs, w_fetch_ok;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic [1:0]            w_fetch_burst;
    logic [DATA_WIDTH-1:0] w_fetch_data;
    logic [MEM_AW-1:0]     w_widx;

`ifdef AXI_MS_BACKPRESSURE_EN
    logic       r_wgap, r_rgap;
    logic [1:0] r_bdly;

    // One idle cycle after each non-final W/R beat; B response held off two cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wgap <= 1'b0;
            r_rgap <= 1'b0;
            r_bdly <= 2'd0;
        end else begin
            r_wgap <= w_wvalid && w_wready && !w_w_end;
            r_rgap <= w_rvalid && w_rready && !w_rlast;
            if (w_wvalid && w_wready && w_w_end) r_bdly <= 2'd2;
            else if (r_bdly != 2'd0)             r_bdly <= r_bdly - 2'd1;
        end
    end

    assign w_wgap  = r_wgap;
    assign w_rgap  = r_rgap;
    assign w_bwait = (r_bdly != 2'd0);
`else
    assign w_wgap  = 1'b0;
    assign w_rgap  = 1'b0;
    assign w_bwait = 1'b0;
`endif

    assign w_w_end = w_wlast || (r_wcnt == r_wlen);
    assign w_wok   = ((r_waddr >> ADDR_LSB) < ADDR_WIDTH'(MEM_WORDS)) && (r_wburst == BURST_INCR);
    assign w_widx  = r_waddr[ADDR_LSB +: MEM_AW];
    assign w_bresp = r_werr ? RESP_SLVERR : RESP_OKAY;
    assign w_bid   = r_wid;

    // Slave write next-state and READY/VALID
    always_comb begin
        w_sw_next = r_sw_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_sw_state)
            W_IDLE: begin
                w_awready = r_s_live;
                if (w_awvalid && r_s_live) w_sw_next = W_DATA;
                else                       w_sw_next = W_IDLE;
            end
            W_DATA: begin
                w_wready = !w_wgap;
                if (w_wvalid && !w_wgap && w_w_end) w_sw_next = W_RESP;
                else                                w_sw_next = W_DATA;
            end
            W_RESP: begin
                w_bvalid = !w_bwait;
                if (!w_bwait && w_bready) w_sw_next = W_IDLE;
                else                      w_sw_next = W_RESP;
            end
            default: w_sw_next = W_IDLE;
        endcase
    end

    // Slave write state, address tracking and error accumulation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_state <= W_IDLE;
            r_s_live   <= 1'b0;
            r_waddr    <= '0;
            r_wsize    <= 3'd0;
            r_wburst   <= 2'b00;
            r_wid      <= '0;
            r_wlen     <= 8'd0;
            r_wcnt     <= 8'd0;
            r_werr     <= 1'b0;
        end else begin
            r_sw_state <= w_sw_next;
            r_s_live   <= 1'b1;
            if (w_awvalid && w_awready) begin
                r_waddr  <= w_awaddr;
                r_wsize  <= w_awsize;
                r_wburst <= w_awburst;
                r_wid    <= w_awid;
                r_wlen   <= w_awlen;
                r_wcnt   <= 8'd0;
                r_werr   <= 1'b0;
            end else if (w_wvalid && w_wready) begin
                r_waddr <= r_waddr + (ADDR_WIDTH'(1) << r_wsize);
                r_wcnt  <= r_wcnt + 8'd1;
                if (!w_wok) r_werr <= 1'b1;
            end
        end
    end

    // Memory array (deliberately not reset); out-of-range beats are dropped
    always_ff @(posedge clock) begin
        if (w_wvalid && w_wready && w_wok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wstrb[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Next read word is fetched on the AR handshake and on every R handshake
    assign w_ar_hs       = w_arvalid && w_arready;
    assign w_r_hs        = w_rvalid && w_rready;
    assign w_fetch_addr  = w_ar_hs ? w_araddr : (r_raddr + (ADDR_WIDTH'(1) << r_rsize));
    assign w_fetch_burst = w_ar_hs ? w_arburst : r_rburst;
    assign w_fetch_ok    = ((w_fetch_addr >> ADDR_LSB) < ADDR_WIDTH'(MEM_WORDS)) &&
                           (w_fetch_burst == BURST_INCR);
    assign w_fetch_data  = w_fetch_ok ? r_mem[w_fetch_addr[ADDR_LSB +: MEM_AW]] : '0;
    assign w_rdata       = r_rdata;
    assign w_rresp       = r_rresp;
    assign w_rid         = r_rid;
    assign w_rlast       = (r_sr_state == R_DATA) && (r_rcnt == r_rlen);

    // Slave read next-state and READY/VALID
    always_comb begin
        w_sr_next = r_sr_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_sr_state)
            R_IDLE: begin
                w_arready = r_s_live;
                if (w_arvalid && r_s_live) w_sr_next = R_DATA;
                else                       w_sr_next = R_IDLE;
            end
            R_DATA: begin
                w_rvalid = !w_rgap;
                if (!w_rgap && w_rready && w_rlast) w_sr_next = R_IDLE;
                else                                w_sr_next = R_DATA;
            end
            default: w_sr_next = R_IDLE;
        endcase
    end

    // Slave read state and registered read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr_state <= R_IDLE;
            r_raddr    <= '0;
            r_rsize    <= 3'd0;
            r_rburst   <= 2'b00;
            r_rid      <= '0;
            r_rlen     <= 8'd0;
            r_rcnt     <= 8'd0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_sr_state <= w_sr_next;
            if (w_ar_hs) begin
                r_rsize  <= w_arsize;
                r_rburst <= w_arburst;
                r_rid    <= w_arid;
                r_rlen   <= w_arlen;
                r_rcnt   <= 8'd0;
            end else if (w_r_hs) begin
                r_rcnt <= r_rcnt + 8'd1;
            end
            if (w_ar_hs || w_r_hs) begin
                r_raddr <= w_fetch_addr;
                r_rdata <= w_fetch_data;
                r_rresp <= w_fetch_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_axi_master_slave.sv
// Self-checking bench for axi_master_slave: scenario table with randomized mid-run resets,
// a negedge protocol monitor, and a second instance with a shrunken memory.
`timescale 1ns/1ps
module tb_axi_master_slave;
    localparam int NB    = 4;
    localparam int BL    = 8;
    localparam int BYTES = 4;
    localparam int TOTAL = NB * BL;
`ifdef AXI_MS_BACKPRESSURE_EN
    localparam int SPAN = 2 * BL - 1;
`else
    localparam int SPAN = BL;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rst16_n = 1'b1;
    logic        done, error, done16, error16;
    logic [15:0] beats_ok, beats_ok16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_master_slave dut (.clock(clk), .reset(rst_n), .done(done), .error(error), .beats_ok(beats_ok));
    axi_master_slave #(.MEM_WORDS(16)) dut16 (.clock(clk), .reset(rst16_n), .done(done16),
                                             .error(error16), .beats_ok(beats_ok16));

    typedef struct {
        int mid_cycle;
        int mid_len;
        int exp_beats;
        bit exp_err;
    } scen_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: beat (b,k) lands at byte address b*BL*BYTES + k*BYTES; it is good iff in memory
    function automatic int model_beats_ok(input int mem_words);
        int n = 0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < BL; k++)
                if ((b * BL * BYTES + k * BYTES) / BYTES < mem_words) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_word(input int i);
        return 32'hC0DE_0000 + i;
    endfunction

    // ---------------- protocol monitor (samples mid-cycle) ----------------
    int viol, wlast_cnt, rlast_cnt, w_span_bad, r_span_bad, done_bad;
    int w_cyc, r_cyc;
    bit w_act, r_act, p_aw, p_w, p_ar, p_r, done_next;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic        s_wlast, s_rlast;

    always @(negedge clk) begin
        if (!rst_n) begin
            viol = 0; wlast_cnt = 0; rlast_cnt = 0; w_span_bad = 0; r_span_bad = 0; done_bad = 0;
            w_act = 0; r_act = 0; p_aw = 0; p_w = 0; p_ar = 0; p_r = 0; done_next = 0;
        end else begin
            if (p_aw && !(dut.w_awvalid && dut.w_awaddr == s_awaddr)) viol++;
            if (p_ar && !(dut.w_arvalid && dut.w_araddr == s_araddr)) viol++;
            if (p_w && !(dut.w_wvalid && dut.w_wdata == s_wdata && dut.w_wlast == s_wlast)) viol++;
            if (p_r && !(dut.w_rvalid && dut.w_rdata == s_rdata && dut.w_rlast == s_rlast)) viol++;
            p_aw = dut.w_awvalid && !dut.w_awready; s_awaddr = dut.w_awaddr;
            p_ar = dut.w_arvalid && !dut.w_arready; s_araddr = dut.w_araddr;
            p_w  = dut.w_wvalid && !dut.w_wready;   s_wdata = dut.w_wdata; s_wlast = dut.w_wlast;
            p_r  = dut.w_rvalid && !dut.w_rready;   s_rdata = dut.w_rdata; s_rlast = dut.w_rlast;
            if (w_act) w_cyc++;
            if (dut.w_wvalid && dut.w_wready) begin
                if (!w_act) begin w_act = 1; w_cyc = 1; end
                if (dut.w_wlast) begin
                    wlast_cnt++;
                    if (w_cyc != SPAN) w_span_bad++;
                    w_act = 0;
                end
            end
            if (r_act) r_cyc++;
            if (done_next) begin
                if (done !== 1'b1) done_bad++;
                done_next = 0;
            end
            if (dut.w_rvalid && dut.w_rready) begin
                if (!r_act) begin r_act = 1; r_cyc = 1; end
                if (dut.w_rlast) begin
                    rlast_cnt++;
                    if (r_cyc != SPAN) r_span_bad++;
                    r_act = 0;
                    if (rlast_cnt == NB) begin
                        if (done !== 1'b0) done_bad++;
                        done_next = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_reset(input int len, input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_async_done"}, done, 1'b0);
        check({tag, "_async_error"}, error, 1'b0);
        check({tag, "_async_beats"}, beats_ok, 16'd0);
        check({tag, "_async_valids"}, {dut.w_awvalid, dut.w_wvalid, dut.w_arvalid,
                                      dut.w_rvalid, dut.w_bvalid, dut.w_wready}, 6'd0);
        repeat (len) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_and_check(input string tag, input int exp_beats, input bit exp_err);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_within_200"}, (done === 1'b1 && cyc <= 200), 1'b1);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_beats_ok"}, beats_ok, exp_beats);
        check({tag, "_wlast_count"}, wlast_cnt, NB);
        check({tag, "_rlast_count"}, rlast_cnt, NB);
        check({tag, "_valid_stability"}, viol, 0);
        check({tag, "_w_burst_span"}, w_span_bad, 0);
        check({tag, "_r_burst_span"}, r_span_bad, 0);
        check({tag, "_done_timing"}, done_bad, 0);
        for (int i = 0; i < TOTAL; i++)
            check($sformatf("%s_mem%0d", tag, i), dut.r_mem[i], model_word(i));
    endtask

    initial begin
        scen_t tbl[4];
        int    wcyc;
        int    exp_full = model_beats_ok(256);
        tbl[0] = '{0, 0, exp_full, exp_full != TOTAL};
        for (int s = 1; s < 4; s++)
            tbl[s] = '{int'($urandom_range(10, 150)), int'($urandom_range(1, 4)),
                       exp_full, exp_full != TOTAL};

        #1 rst_n = 1'b0; rst16_n = 1'b0;
        #9;
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_beats", beats_ok, 16'd0);
        check("reset_valids_ready", {dut.w_awvalid, dut.w_wvalid, dut.w_arvalid, dut.w_rvalid,
                                     dut.w_bvalid, dut.w_awready, dut.w_arready, dut.w_wready,
                                     dut.w_bready, dut.w_rready}, 10'd0);
        #10 rst_n = 1'b1; rst16_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            if (s != 0) pulse_reset(3, $sformatf("s%0d_pre", s));
            if (tbl[s].mid_cycle > 0) begin
                repeat (tbl[s].mid_cycle) @(posedge clk);
                pulse_reset(tbl[s].mid_len, $sformatf("s%0d_mid", s));
            end
            run_and_check($sformatf("s%0d", s), tbl[s].exp_beats, tbl[s].exp_err);
        end

        // Reset held 3 cycles while burst 2 is being written
        pulse_reset(2, "b2_pre");
        wcyc = 0;
        while (!(dut.w_wvalid === 1'b1 && dut.r_burst == 8'd2) && wcyc < 200) begin
            @(negedge clk);
            wcyc++;
        end
        check("b2_reached_burst2_write", wcyc < 200, 1'b1);
        pulse_reset(3, "b2_mid");
        run_and_check("b2", exp_full, exp_full != TOTAL);

        // Shrunken memory: beats past the end get SLVERR and read back as zero
        wcyc = 0;
        while (done16 !== 1'b1 && wcyc < 300) begin
            @(negedge clk);
            wcyc++;
        end
        check("m16_done", done16, 1'b1);
        check("m16_error", error16, model_beats_ok(16) != TOTAL);
        check("m16_beats_ok", beats_ok16, model_beats_ok(16));
        for (int i = 0; i < 16; i++)
            check($sformatf("m16_mem%0d", i), dut16.r_mem[i], model_word(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
